// File: rtl/serializer_pkg.sv
// Shared types and helpers for the symbol serializer: bits-per-symbol codes,
// FSM state encoding and symbol-count arithmetic.
package serializer_pkg;

  localparam logic [1:0] BPS_1 = 2'b00;
  localparam logic [1:0] BPS_2 = 2'b01;
  localparam logic [1:0] BPS_4 = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // The reserved code 2'b11 falls back to one bit per symbol.
  function automatic int unsigned bps_decode(input logic [1:0] sel);
    case (sel)
      BPS_2:   return 2;
      BPS_4:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned num_symbols(input int unsigned width,
                                              input int unsigned bps);
    return (width + bps - 1) / bps;
  endfunction

endpackage

// File: rtl/symbol_serializer_extract.sv
// Picks the leading bps bits of the shift register (top for MSB-first,
// bottom for LSB-first) and zeroes the unused upper symbol bits.
module symbol_extract #(
  parameter int WIDTH   = 9,
  parameter int MAX_BPS = 4
) (
  input  logic [WIDTH-1:0]   i_sreg,
  input  logic [2:0]         i_bps,
  input  logic               i_lsb_first,
  output logic [MAX_BPS-1:0] o_sym
);

  logic [WIDTH-1:0]   w_top;
  logic [MAX_BPS-1:0] w_mask;
  logic [MAX_BPS-1:0] w_raw;

  // NOTE: combinational blocks use blocking (=) assignments so later
  // statements see the values computed earlier in the same evaluation.
  always_comb begin
    w_top  = i_sreg >> (WIDTH - int'(i_bps));
    w_mask = '0;
    for (int k = 0; k < MAX_BPS; k++) begin
      if (k < int'(i_bps)) w_mask[k] = 1'b1;
    end
    w_raw = i_lsb_first ? i_sreg[MAX_BPS-1:0] : w_top[MAX_BPS-1:0];
    o_sym = w_raw & w_mask;
  end

endmodule

// File: rtl/symbol_serializer.sv
// Parallel-to-serial converter emitting 1/2/4-bit symbols with valid/ready
// on both sides; a new word can load on the final-symbol handshake.
module symbol_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int MAX_BPS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [1:0]         bps_sel,
  input  logic               lsb_first,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic [MAX_BPS-1:0] sym_out,
  output logic               sym_last,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_sreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bps;
  logic               r_lsb_first;

  logic               w_last;
  logic               w_load;
  logic               w_sym_fire;
  logic [2:0]         w_new_bps;
  logic [CNT_W-1:0]   w_new_cnt;
  logic [MAX_BPS-1:0] w_sym;

  assign w_new_bps  = 3'(bps_decode(bps_sel));
  assign w_new_cnt  = CNT_W'(num_symbols(WIDTH, bps_decode(bps_sel)));
  assign w_last     = (r_cnt == CNT_W'(1));
  assign w_load     = load_valid && load_ready;
  assign w_sym_fire = sym_valid && sym_ready;

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    load_ready   = 1'b0;
    sym_valid    = 1'b0;
    sym_last     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        sym_valid  = 1'b1;
        busy       = 1'b1;
        sym_last   = w_last;
        load_ready = w_last && sym_ready;
        if (w_last && sym_ready && !load_valid) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // A load takes priority over the shift: it only coincides with the final
  // symbol, whose remaining bits are discarded anyway.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_bps       <= '0;
      r_lsb_first <= 1'b0;
    end else if (w_load) begin
      r_sreg      <= data_in;
      r_cnt       <= w_new_cnt;
      r_bps       <= w_new_bps;
      r_lsb_first <= lsb_first;
    end else if (w_sym_fire) begin
      r_sreg <= r_lsb_first ? (r_sreg >> r_bps) : (r_sreg << r_bps);
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  symbol_extract #(
    .WIDTH  (WIDTH),
    .MAX_BPS(MAX_BPS)
  ) u_extract (
    .i_sreg     (r_sreg),
    .i_bps      (r_bps),
    .i_lsb_first(r_lsb_first),
    .o_sym      (w_sym)
  );

  assign sym_out = sym_valid ? w_sym : '0;

endmodule

// File: tb/tb_symbol_serializer.sv
// Self-checking bench for symbol_serializer: directed sequences plus random
// traffic against a queue-based model of the expected symbol stream.
module tb_symbol_serializer;

  localparam int W   = 9;
  localparam int MB  = 4;

  logic          clk;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          load_valid;
  logic          load_ready;
  logic [1:0]    bps_sel;
  logic          lsb_first;
  logic          sym_valid;
  logic          sym_ready;
  logic [MB-1:0] sym_out;
  logic          sym_last;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  int exp_q[$];   // symbols still owed by the DUT for the current word(s)
  int got_q[$];   // symbols the DUT actually handed over
  int lr_pulses;

  symbol_serializer #(.WIDTH(W), .MAX_BPS(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .bps_sel   (bps_sel),
    .lsb_first (lsb_first),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_out   (sym_out),
    .sym_last  (sym_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Split a word into symbols: MSB-first pads the word on the right to a
  // whole number of symbols; LSB-first reads the word from bit 0 upward.
  function automatic void push_word(input int d, input logic [1:0] sel, input logic lsb);
    int bps, n, mask, padded;
    bps  = (sel == 2'b01) ? 2 : (sel == 2'b10) ? 4 : 1;
    n    = (W + bps - 1) / bps;
    mask = (1 << bps) - 1;
    padded = d << (n * bps - W);
    for (int i = 0; i < n; i++) begin
      if (lsb) exp_q.push_back((d >> (i * bps)) & mask);
      else     exp_q.push_back((padded >> ((n - 1 - i) * bps)) & mask);
    end
  endfunction

  // One clock cycle: drive after the falling edge, check, predict the edge.
  task automatic step(input logic lv, input logic [W-1:0] d, input logic [1:0] sel,
                      input logic lsb, input logic sr, input logic rst_n, output bit acc);
    bit ev, elr;
    load_valid = lv;
    data_in    = d;
    bps_sel    = sel;
    lsb_first  = lsb;
    sym_ready  = sr;
    reset      = rst_n;
    #1;
    ev  = (exp_q.size() > 0);
    elr = !ev || (exp_q.size() == 1 && sr);
    check("sym_valid", 32'(sym_valid), 32'(ev));
    check("busy", 32'(busy), 32'(ev));
    check("load_ready", 32'(load_ready), 32'(elr));
    if (ev) begin
      check("sym_out", 32'(sym_out), 32'(exp_q[0]));
      check("sym_last", 32'(sym_last), 32'(exp_q.size() == 1));
    end else begin
      check("sym_out_idle", 32'(sym_out), 32'd0);
      check("sym_last_idle", 32'(sym_last), 32'd0);
    end
    if (load_ready) lr_pulses++;
    acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (ev && sr) begin
        got_q.push_back(int'(sym_out));
        void'(exp_q.pop_front());
      end
      if (lv && elr) begin
        acc = 1'b1;
        push_word(int'(d), sel, lsb);
      end
    end
    @(negedge clk);
  endtask

  // rmode 0: always ready; rmode 1: ready pattern 1,0,0,1 then random.
  task automatic run_word(input logic [W-1:0] d, input logic [1:0] sel,
                          input logic lsb, input int rmode);
    bit loaded = 1'b0;
    bit acc;
    int guard = 0;
    logic sr;
    logic [3:0] pat = 4'b1001;
    got_q.delete();
    while ((!loaded || exp_q.size() > 0) && guard < 200) begin
      if (rmode == 0)     sr = 1'b1;
      else if (guard < 4) sr = pat[3 - guard];
      else                sr = 1'($urandom_range(0, 1));
      step(!loaded, d, sel, lsb, sr, 1'b1, acc);
      loaded |= acc;
      guard++;
    end
    check("word_done_in_budget", 32'(guard < 200), 32'd1);
  endtask

  task automatic compare_seq(input string tag, input int exp[$]);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp[i]));
  endtask

  initial begin
    bit acc;
    int guard;
    int s1[$]  = '{1, 0, 1, 1, 0, 0, 1, 1, 1};
    int s2[$]  = '{2, 3, 0, 3, 2};
    int s4[$]  = '{11, 3, 8};
    int s2l[$] = '{3, 1, 2, 1, 1};
    int sff[$] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};

    reset = 1'b0; load_valid = 1'b0; data_in = '0;
    bps_sel = 2'b00; lsb_first = 1'b0; sym_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state observed with reset released and nothing loaded.
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b1, acc);

    run_word(9'h167, 2'b00, 1'b0, 0);  compare_seq("msb_bps1", s1);
    run_word(9'h167, 2'b01, 1'b0, 0);  compare_seq("msb_bps2", s2);
    run_word(9'h167, 2'b10, 1'b0, 0);  compare_seq("msb_bps4", s4);
    run_word(9'h167, 2'b01, 1'b1, 0);  compare_seq("lsb_bps2", s2l);
    run_word(9'h167, 2'b01, 1'b0, 1);  compare_seq("backpressure_bps2", s2);

    // Back-to-back: 0x0FF held during the first word; exactly one load_ready
    // pulse, on the final-symbol handshake.
    got_q.delete();
    step(1'b1, 9'h167, 2'b01, 1'b0, 1'b1, 1'b1, acc);
    lr_pulses = 0;
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 50) begin
      step(1'b1, 9'h0FF, 2'b00, 1'b0, 1'b1, 1'b1, acc);
      guard++;
    end
    check("b2b_lr_pulses", 32'(lr_pulses), 32'd1);
    check("b2b_no_gap", 32'(sym_valid), 32'd1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      step(1'b0, '0, 2'b11, 1'b1, 1'b1, 1'b1, acc);
      guard++;
    end
    check("b2b_done_in_budget", 32'(guard < 50), 32'd1);
    check("b2b_seq_len", 32'(got_q.size()), 32'd14);
    if (got_q.size() == 14) begin
      for (int i = 0; i < 9; i++) check("b2b_second_word", 32'(got_q[5 + i]), 32'(sff[i]));
    end

    // Reset mid-word after three symbols, then a clean restart.
    step(1'b1, 9'h167, 2'b00, 1'b0, 1'b1, 1'b1, acc);
    repeat (3) step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 9'h0AA, 2'b10, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b1, acc);
    run_word(9'h167, 2'b00, 1'b0, 0);  compare_seq("after_reset", s1);

    // Random traffic: config and data wiggle freely; only loads count.
    for (int c = 0; c < 3000; c++) begin
      step(1'(($urandom % 3) != 0), W'($urandom), 2'($urandom), 1'($urandom),
           1'(($urandom % 4) != 0), 1'(($urandom % 200) != 0), acc);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b1, acc);
      guard++;
    end
    check("random_drain_in_budget", 32'(guard < 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
